rca32_seq_multiplier: RTL

Unsigned 32x32->64 sequential shift-add multiplier built around one instance of the team's 32-bit ripple-carry adder (`_32bit_rca`).
- Consumes the adder's s/c_out every cycle and feeds the next partial sum back into it.
- One bit of the multiplier is retired per cycle.
- Sits directly behind the adder in the ALU datapath and gives the ALU a multiply op without a combinational array.

---
 rtl/rca32_seq_multiplier.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/rca32_seq_multiplier.sv
// ---------------------------------------------------------------------------
// rca32_seq_multiplier
//   Unsigned 32x32->64 sequential shift-add multiplier. One multiplier bit is
//   retired per clock. Each cycle, a single 32-bit ripple-carry adder adds
//   either the multiplicand or zero into the high half of the accumulator.
//
//   Ports:
//     clk    in   1   single clock, rising edge
//     rst    in   1   asynchronous reset, active high
//     start  in   1   request, accepted only while ready=1
//     a      in  32   multiplicand, sampled on accept
//     b      in  32   multiplier, sampled on accept
//     ready  out  1   high in IDLE only
//     busy   out  1   high in RUN only
//     done   out  1   one-cycle pulse, product final
//     p      out 64   product {acc_hi, acc_lo}, stable from done to next accept
//
//   Also contains _32bit_rca, the 32-bit ripple-carry adder used by the
//   multiplier.
// ---------------------------------------------------------------------------

module _32bit_rca (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c_in,
    output logic [31:0] s,
    output logic        c_out
);
    logic [32:0] w_c;

    assign w_c[0] = c_in;

    genvar i;
    for (i = 0; i < 32; i++) begin : g_fa
        assign s[i]     = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign c_out = w_c[32];
endmodule

module rca32_seq_multiplier #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);
    // The datapath is hard-wired to the 32-bit adder.
    if (WIDTH != 32) begin : g_bad_width
        $error("rca32_seq_multiplier: WIDTH must be 32");
    end
    if (CNT_W != 5) begin : g_bad_cnt_w
        $error("rca32_seq_multiplier: CNT_W must be 5");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_acc_hi;
    logic [WIDTH-1:0]   r_acc_lo;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ready;
    logic               r_busy;
    logic               r_done;

    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;

    // The LSB of acc_lo is the multiplier bit being retired this cycle.
    assign w_addend = r_acc_lo[0] ? r_mcand : {WIDTH{1'b0}};

    _32bit_rca u_rca (
        .a     (r_acc_hi),
        .b     (w_addend),
        .c_in  (1'b0),
        .s     (w_sum),
        .c_out (w_cout)
    );

    // Control FSM and accumulator datapath, all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_mcand  <= {WIDTH{1'b0}};
            r_acc_hi <= {WIDTH{1'b0}};
            r_acc_lo <= {WIDTH{1'b0}};
            r_cnt    <= {CNT_W{1'b0}};
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand  <= a;
                        r_acc_hi <= {WIDTH{1'b0}};
                        r_acc_lo <= b;
                        r_cnt    <= {CNT_W{1'b0}};
                        r_ready  <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end else begin
                        // Hold everything so p keeps the last product.
                        r_state  <= S_IDLE;
                    end
                end
                S_RUN: begin
                    // Shift the 65-bit {c_out, s, acc_lo} right by one; the
                    // carry lands in acc_hi[31] so nothing is lost.
                    r_acc_hi <= {w_cout, w_sum[WIDTH-1:1]};
                    r_acc_lo <= {w_sum[0], r_acc_lo[WIDTH-1:1]};
                    r_cnt    <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (r_cnt == {CNT_W{1'b1}}) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign ready = r_ready;
    assign busy  = r_busy;
    assign done  = r_done;
    assign p     = {r_acc_hi, r_acc_lo};
endmodule
